branch_resolve: RTL and testbench
=================================

Name: branch_resolve

Overview:
- Consumer end of the branch-prediction interface: carries each D-stage branch and its taken/not-taken prediction through E, evaluates the real condition in E, and detects mispredictions.
- On a mispredict it issues a redirect PC and flush request; on a not-taken branch-likely it nullifies the delay slot.
- Registers the resolved outcome into M as the predictor's training port (pcM, branchM, actual_takeM).
- Sits between the decode stage, the forwarding network (rs/rt operands in E) and the hazard unit.

Parameters:
- RESET_PC, 32'hBFC0_0000, value of redirect_pcE and pcM under reset.
- DELAY_SLOT, 1, 1 = MIPS delay-slot semantics (fall-through PC = pcE+8); 0 = no slot (fall-through PC = pcE+4).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- stallE  in  1  hold the D→E register
- flushE  in  1  clear the D→E register (a bubble enters E)
- stallM  in  1  hold the E→M register
- flushM  in  1  clear the E→M register
- instrD  in  32  D-stage instruction (opcode, rt, funct used for condition decode)
- pcD  in  32  D-stage PC
- immD  in  32  sign-extended 16-bit offset
- branchD  in  1  D instruction is a conditional branch
- branchL_D  in  1  D instruction is a branch-likely
- pred_takeD  in  1  predictor said taken (already gated by branchD)
- rs_valueE  in  32  forwarded rs operand in E
- rt_valueE  in  32  forwarded rt operand in E
- mispredictE  out  1  E branch direction differs from its prediction
- redirect_pcE  out  32  correct next fetch PC, valid when mispredictE=1
- nullify_slotE  out  1  branch-likely in E resolved not taken; kill its delay slot
- pcM  out  32  M-stage branch PC (predictor update index)
- branchM  out  1  M instruction is a conditional branch
- actual_takeM  out  1  resolved direction in M

Behaviour:
- D→E register holds branch, likely, pred_take, pc, target, cond code. Target = pcD + 4 + (immD << 2), 32-bit wrap, computed in D and registered.
- Cond decode (3-bit code, registered):
  - BEQ: rs==rt
  - BNE: rs!=rt
  - BLEZ: rs[31] | rs==0
  - BGTZ: ~rs[31] & rs!=0
  - BLTZ/BLTZAL: rs[31]
  - BGEZ/BGEZAL: ~rs[31]
  - Likely variants map to the same code.
  - Signed compare only; no arithmetic overflow is possible.
- E (combinational, zero latency):
  - actual_takeE = branchE & cond(rs_valueE, rt_valueE).
  - mispredictE = branchE & (actual_takeE ^ pred_takeE).
  - redirect_pcE = actual_takeE ? targetE : fallthroughE. When mispredictE=0, redirect_pcE still shows that value; it is don't-care to consumers.
- nullify_slotE = branchE & likelyE & ~actual_takeE. A not-taken likely branch always nullifies its slot, whatever it was predicted.
- If nullify_slotE=1 and mispredictE=1 together, both assert. The hazard unit kills the slot and redirects.
- E→M register: pcM <= pcE, branchM <= branchE, actual_takeM <= actual_takeE.
  - Exactly one update per branch, even if stallE holds E for many cycles.
  - While stallM=1 (M holds), branchM is held, not pulsed again.
- Stall/flush priority per register: rst > flush > stall > load.
  - A flush clears branch, likely and pred_take to 0 and keeps the PCs.
  - With stall and flush asserted together, flush wins.
- Outputs are gated by branchE. A bubble or non-branch in E never asserts mispredictE or nullify_slotE.
- Reset:
  - All valid bits 0.
  - pcM and redirect_pcE = RESET_PC, target 0.
  - mispredictE, nullify_slotE, branchM, actual_takeM = 0 in the cycle after rst.
  - A rst asserted mid-stall discards in-flight branches with no update.

Optional Feature:
- Macro: BRANCH_PERF_EN.
- When defined, adds outputs perf_branch_cnt[31:0] and perf_mispred_cnt[31:0].
  - Each increments once per branch leaving E→M (branchE & ~stallM & ~flushM); the second counter only on a mispredict.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- When undefined, these ports and their logic are absent and all other behaviour is unchanged.

Decomposition:
- Shared package holds:
  - 3-bit cond-code constants (COND_EQ, COND_NE, COND_LEZ, COND_GTZ, COND_LTZ, COND_GEZ).
  - Opcode constants REGIMM_INST, BEQ..BGTZL.
  - RESET_PC.
- One sub-module, branch_cond_eval: purely combinational, (cond, rs, rt) → taken. It is reusable by the ALU test bench.

Test Plan:
- BEQ, pcD=0x8000_0100, immD=0x10, pred_takeD=0, rs=rt=5 → next cycle mispredictE=1, redirect_pcE=0x8000_0144; one cycle later branchM=1, actual_takeM=1, pcM=0x8000_0100.
- BNE predicted taken, rs=rt=7 → mispredictE=1, redirect_pcE=pcE+8; actual_takeM=0.
- BGTZL, rs=0xFFFF_FFFF, pred_takeD=1 → mispredictE=1, nullify_slotE=1, redirect_pcE=pcE+8.
- BLEZ predicted taken with rs=0 held under stallE for 3 cycles → mispredictE=0 throughout; branchM pulses exactly once.
- flushE asserted together with stallE while a predicted-taken branch is in D → E becomes a bubble; no mispredictE, no branchM.
- rst asserted with branches in E and M → next cycle all outputs 0, pcM=RESET_PC. With BRANCH_PERF_EN, counters read 0.

Source files
------------

// File: rtl/branch_resolve_pkg.sv
// -----------------------------------------------------------------------------
// branch_resolve_pkg
//   Shared definitions for the branch resolution block:
//     - cond_e       : 3-bit branch condition codes evaluated in E
//     - opcode values for the MIPS conditional branches (incl. likely forms)
//     - RESET_PC     : default reset fetch address
//     - decode_cond  : maps (opcode, rt[0]) to a condition code
// -----------------------------------------------------------------------------
package branch_resolve_pkg;

    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

    typedef enum logic [2:0] {
        COND_EQ  = 3'd0,
        COND_NE  = 3'd1,
        COND_LEZ = 3'd2,
        COND_GTZ = 3'd3,
        COND_LTZ = 3'd4,
        COND_GEZ = 3'd5
    } cond_e;

    localparam logic [5:0] REGIMM_INST = 6'h01;
    localparam logic [5:0] BEQ         = 6'h04;
    localparam logic [5:0] BNE         = 6'h05;
    localparam logic [5:0] BLEZ        = 6'h06;
    localparam logic [5:0] BGTZ        = 6'h07;
    localparam logic [5:0] BEQL        = 6'h14;
    localparam logic [5:0] BNEL        = 6'h15;
    localparam logic [5:0] BLEZL       = 6'h16;
    localparam logic [5:0] BGTZL       = 6'h17;

    // REGIMM branches (BLTZ/BGEZ, their AL and likely forms) differ only in
    // rt[0]: 0 = less-than-zero, 1 = greater-or-equal-zero.
    function automatic cond_e decode_cond(input logic [5:0] op, input logic rt_lsb);
        cond_e c;
        c = COND_EQ;
        case (op)
            BEQ, BEQL:   c = COND_EQ;
            BNE, BNEL:   c = COND_NE;
            BLEZ, BLEZL: c = COND_LEZ;
            BGTZ, BGTZL: c = COND_GTZ;
            REGIMM_INST: c = rt_lsb ? COND_GEZ : COND_LTZ;
            default:     c = COND_EQ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// -----------------------------------------------------------------------------
// branch_cond_eval
//   Purely combinational branch condition evaluator (signed compares only).
//   Ports:
//     cond   in  cond_e  condition code
//     rs     in  32      rs operand
//     rt     in  32      rt operand (used by EQ/NE only)
//     taken  out 1       condition holds
// -----------------------------------------------------------------------------
module branch_cond_eval
    import branch_resolve_pkg::*;
(
    input  cond_e       cond,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    output logic        taken
);

    logic rs_zero;
    logic rs_neg;

    assign rs_zero = (rs == 32'd0);
    assign rs_neg  = rs[31];

    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_EQ:  taken = (rs == rt);
            COND_NE:  taken = (rs != rt);
            COND_LEZ: taken = rs_neg | rs_zero;
            COND_GTZ: taken = ~rs_neg & ~rs_zero;
            COND_LTZ: taken = rs_neg;
            COND_GEZ: taken = ~rs_neg;
            default:  taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve.sv
// -----------------------------------------------------------------------------
// branch_resolve
//   Carries a D-stage branch and its prediction into E, resolves the real
//   direction there, flags mispredictions (with the corrected fetch PC) and
//   nullifies the delay slot of a not-taken branch-likely. The resolved outcome
//   is registered into M as the predictor training port.
//
//   Parameters:
//     RESET_PC    reset value of redirect_pcE and pcM
//     DELAY_SLOT  1: fall-through = pc+8, 0: fall-through = pc+4
//
//   Ports:
//     clk, rst                     clock, synchronous active-high reset
//     stallE, flushE               hold / clear the D->E register
//     stallM, flushM               hold / clear the E->M register
//     instrD, pcD, immD            D-stage instruction, PC, sign-extended offset
//     branchD, branchL_D           D is a conditional branch / branch-likely
//     pred_takeD                   predicted taken
//     rs_valueE, rt_valueE         forwarded operands in E
//     mispredictE, redirect_pcE    direction mismatch and the correct next PC
//     nullify_slotE                kill the delay slot of a not-taken likely
//     pcM, branchM, actual_takeM   predictor update port
//
//   Optional (macro BRANCH_PERF_EN):
//     perf_branch_cnt, perf_mispred_cnt  saturating branch / mispredict counters
// -----------------------------------------------------------------------------
module branch_resolve #(
    parameter logic [31:0] RESET_PC   = branch_resolve_pkg::RESET_PC,
    parameter bit          DELAY_SLOT = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallE,
    input  logic        flushE,
    input  logic        stallM,
    input  logic        flushM,
    input  logic [31:0] instrD,
    input  logic [31:0] pcD,
    input  logic [31:0] immD,
    input  logic        branchD,
    input  logic        branchL_D,
    input  logic        pred_takeD,
    input  logic [31:0] rs_valueE,
    input  logic [31:0] rt_valueE,
    output logic        mispredictE,
    output logic [31:0] redirect_pcE,
    output logic        nullify_slotE,
    output logic [31:0] pcM,
    output logic        branchM,
    output logic        actual_takeM
`ifdef BRANCH_PERF_EN
    ,
    output logic [31:0] perf_branch_cnt,
    output logic [31:0] perf_mispred_cnt
`endif
);

    import branch_resolve_pkg::*;

    localparam logic [31:0] FALL_OFS = DELAY_SLOT ? 32'd8 : 32'd4;

    // ---------------- D stage: precompute target, fall-through, cond ----------
    logic [31:0] target_dv;
    logic [31:0] fall_dv;
    cond_e       cond_dv;
    logic        unused_instr_bits;

    assign target_dv = pcD + 32'd4 + {immD[29:0], 2'b00};
    assign fall_dv   = pcD + FALL_OFS;
    assign cond_dv   = decode_cond(instrD[31:26], instrD[16]);

    // Fields not needed for condition decode.
    assign unused_instr_bits = ^{instrD[25:21], instrD[20:17], instrD[15:0], immD[31:30]};

    // ---------------- D -> E register ---------------------------------------
    logic        branch_e_q, branch_e_d;
    logic        likely_e_q, likely_e_d;
    logic        pred_e_q,   pred_e_d;
    logic [31:0] pc_e_q,     pc_e_d;
    logic [31:0] target_e_q, target_e_d;
    logic [31:0] fall_e_q,   fall_e_d;
    cond_e       cond_e_q,   cond_e_d;
    // Set once the branch sitting in E has been handed to M while E is held,
    // so a long stallE produces exactly one predictor update.
    logic        sent_e_q,   sent_e_d;

    // ---------------- E -> M register ---------------------------------------
    logic [31:0] pc_m_q,     pc_m_d;
    logic        branch_m_q, branch_m_d;
    logic        take_m_q,   take_m_d;

    // ---------------- E stage resolution ------------------------------------
    logic cond_taken;
    logic actual_take_e;
    logic branch_out_e;
    logic leave_e;

    branch_cond_eval u_cond (
        .cond  (cond_e_q),
        .rs    (rs_valueE),
        .rt    (rt_valueE),
        .taken (cond_taken)
    );

    assign actual_take_e = branch_e_q & cond_taken;
    assign mispredictE   = branch_e_q & (actual_take_e ^ pred_e_q);
    assign redirect_pcE  = actual_take_e ? target_e_q : fall_e_q;
    assign nullify_slotE = branch_e_q & likely_e_q & ~actual_take_e;

    assign branch_out_e  = branch_e_q & ~sent_e_q;
    assign leave_e       = branch_out_e & ~stallM & ~flushM;

    always_comb begin
        branch_e_d = branch_e_q;
        likely_e_d = likely_e_q;
        pred_e_d   = pred_e_q;
        pc_e_d     = pc_e_q;
        target_e_d = target_e_q;
        fall_e_d   = fall_e_q;
        cond_e_d   = cond_e_q;
        if (flushE) begin
            // Bubble: drop the valid bits, leave PCs as they were.
            branch_e_d = 1'b0;
            likely_e_d = 1'b0;
            pred_e_d   = 1'b0;
        end else if (!stallE) begin
            branch_e_d = branchD;
            likely_e_d = branchL_D;
            pred_e_d   = pred_takeD;
            pc_e_d     = pcD;
            target_e_d = target_dv;
            fall_e_d   = fall_dv;
            cond_e_d   = cond_dv;
        end
    end

    always_comb begin
        sent_e_d = sent_e_q;
        if (flushE || !stallE) begin
            sent_e_d = 1'b0;
        end else if (leave_e) begin
            sent_e_d = 1'b1;
        end
    end

    always_comb begin
        pc_m_d     = pc_m_q;
        branch_m_d = branch_m_q;
        take_m_d   = take_m_q;
        if (flushM) begin
            branch_m_d = 1'b0;
            take_m_d   = 1'b0;
        end else if (!stallM) begin
            pc_m_d     = pc_e_q;
            branch_m_d = branch_out_e;
            take_m_d   = actual_take_e & ~sent_e_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            branch_e_q <= 1'b0;
            likely_e_q <= 1'b0;
            pred_e_q   <= 1'b0;
            pc_e_q     <= RESET_PC;
            target_e_q <= 32'd0;
            // Holding the reset PC here makes redirect_pcE read RESET_PC in reset.
            fall_e_q   <= RESET_PC;
            cond_e_q   <= COND_EQ;
            sent_e_q   <= 1'b0;
            pc_m_q     <= RESET_PC;
            branch_m_q <= 1'b0;
            take_m_q   <= 1'b0;
        end else begin
            branch_e_q <= branch_e_d;
            likely_e_q <= likely_e_d;
            pred_e_q   <= pred_e_d;
            pc_e_q     <= pc_e_d;
            target_e_q <= target_e_d;
            fall_e_q   <= fall_e_d;
            cond_e_q   <= cond_e_d;
            sent_e_q   <= sent_e_d;
            pc_m_q     <= pc_m_d;
            branch_m_q <= branch_m_d;
            take_m_q   <= take_m_d;
        end
    end

    assign pcM          = pc_m_q;
    assign branchM      = branch_m_q;
    assign actual_takeM = take_m_q;

`ifdef BRANCH_PERF_EN
    // ---------------- Saturating performance counters -----------------------
    logic [31:0] perf_branch_q, perf_branch_d;
    logic [31:0] perf_mispred_q, perf_mispred_d;

    always_comb begin
        perf_branch_d  = perf_branch_q;
        perf_mispred_d = perf_mispred_q;
        if (leave_e) begin
            if (perf_branch_q != 32'hFFFF_FFFF) begin
                perf_branch_d = perf_branch_q + 32'd1;
            end
            if (mispredictE && (perf_mispred_q != 32'hFFFF_FFFF)) begin
                perf_mispred_d = perf_mispred_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_branch_q  <= 32'd0;
            perf_mispred_q <= 32'd0;
        end else begin
            perf_branch_q  <= perf_branch_d;
            perf_mispred_q <= perf_mispred_d;
        end
    end

    assign perf_branch_cnt  = perf_branch_q;
    assign perf_mispred_cnt = perf_mispred_q;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// -----------------------------------------------------------------------------
// tb_branch_resolve
//   Directed scenarios plus a randomized stream checked against a behavioural
//   model (signed compares on the instruction fields, pipeline as two slots).
// -----------------------------------------------------------------------------
module tb_branch_resolve;

    localparam logic [31:0] RST_PC = 32'hBFC0_0000;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic        stallE, flushE, stallM, flushM;
    logic [31:0] instrD, pcD, immD;
    logic        branchD, branchL_D, pred_takeD;
    logic [31:0] rs_valueE, rt_valueE;
    logic        mispredictE, nullify_slotE, branchM, actual_takeM;
    logic [31:0] redirect_pcE, pcM;
`ifdef BRANCH_PERF_EN
    logic [31:0] perf_branch_cnt, perf_mispred_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    branch_resolve dut (
        .clk           (clk),
        .rst           (rst),
        .stallE        (stallE),
        .flushE        (flushE),
        .stallM        (stallM),
        .flushM        (flushM),
        .instrD        (instrD),
        .pcD           (pcD),
        .immD          (immD),
        .branchD       (branchD),
        .branchL_D     (branchL_D),
        .pred_takeD    (pred_takeD),
        .rs_valueE     (rs_valueE),
        .rt_valueE     (rt_valueE),
        .mispredictE   (mispredictE),
        .redirect_pcE  (redirect_pcE),
        .nullify_slotE (nullify_slotE),
        .pcM           (pcM),
        .branchM       (branchM),
        .actual_takeM  (actual_takeM)
`ifdef BRANCH_PERF_EN
        ,
        .perf_branch_cnt  (perf_branch_cnt),
        .perf_mispred_cnt (perf_mispred_cnt)
`endif
    );

    // ---------------- reference model ----------------
    function automatic logic ref_cond(input logic [31:0] instr, input logic [31:0] rs, input logic [31:0] rt);
        logic [5:0] op;
        op = instr[31:26];
        case (op)
            6'h04, 6'h14: return rs == rt;
            6'h05, 6'h15: return rs != rt;
            6'h06, 6'h16: return $signed(rs) <= 0;
            6'h07, 6'h17: return $signed(rs) > 0;
            6'h01:        return instr[16] ? ($signed(rs) >= 0) : ($signed(rs) < 0);
            default:      return 1'b0;
        endcase
    endfunction

    function automatic logic ref_likely(input logic [31:0] instr);
        return (instr[31:26] >= 6'h14 && instr[31:26] <= 6'h17) ||
               (instr[31:26] == 6'h01 && instr[17]);
    endfunction

    typedef struct {
        logic        br;
        logic        lk;
        logic        pt;
        logic        tk;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] imm;
    } txn_t;

    // ---------------- driver tasks ----------------
    task automatic do_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_d(input logic [5:0] op, input logic [4:0] rtf, input logic [31:0] pc,
                           input logic [15:0] off, input logic br, input logic pt);
        instrD     = {op, 5'd3, rtf, off};
        pcD        = pc;
        immD       = {{16{off[15]}}, off};
        branchD    = br;
        branchL_D  = br & ref_likely({op, 5'd3, rtf, off});
        pred_takeD = br & pt;
    endtask

    task automatic drive_nop();
        drive_d(6'h09, 5'd0, 32'h0000_1000, 16'h0001, 1'b0, 1'b0);
    endtask

    task automatic idle_cycles(input int n);
        drive_nop();
        for (int i = 0; i < n; i++) do_cycle();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; stallE = 1'b0; flushE = 1'b0; stallM = 1'b0; flushM = 1'b0;
        rs_valueE = 32'd0; rt_valueE = 32'd0;
        drive_nop();
        do_cycle(); do_cycle();
        total++; if (mispredictE !== 1'b0) begin bad++; $display("FAIL reset_mispredict got=%b exp=0", mispredictE); end
        total++; if (nullify_slotE !== 1'b0) begin bad++; $display("FAIL reset_nullify got=%b exp=0", nullify_slotE); end
        total++; if (branchM !== 1'b0) begin bad++; $display("FAIL reset_branchM got=%b exp=0", branchM); end
        total++; if (actual_takeM !== 1'b0) begin bad++; $display("FAIL reset_actual_takeM got=%b exp=0", actual_takeM); end
        total++; if (pcM !== RST_PC) begin bad++; $display("FAIL reset_pcM got=%h exp=%h", pcM, RST_PC); end
        total++; if (redirect_pcE !== RST_PC) begin bad++; $display("FAIL reset_redirect got=%h exp=%h", redirect_pcE, RST_PC); end
        rst = 1'b0;
        idle_cycles(2);
    endtask

    task automatic test_beq();
        drive_d(6'h04, 5'd0, 32'h8000_0100, 16'h0010, 1'b1, 1'b0);
        do_cycle();
        drive_nop(); rs_valueE = 32'd5; rt_valueE = 32'd5; #1;
        total++; if (mispredictE !== 1'b1) begin bad++; $display("FAIL beq_mispredict got=%b exp=1", mispredictE); end
        total++; if (redirect_pcE !== 32'h8000_0144) begin bad++; $display("FAIL beq_redirect got=%h exp=80000144", redirect_pcE); end
        total++; if (nullify_slotE !== 1'b0) begin bad++; $display("FAIL beq_nullify got=%b exp=0", nullify_slotE); end
        do_cycle();
        total++; if (branchM !== 1'b1) begin bad++; $display("FAIL beq_branchM got=%b exp=1", branchM); end
        total++; if (actual_takeM !== 1'b1) begin bad++; $display("FAIL beq_takeM got=%b exp=1", actual_takeM); end
        total++; if (pcM !== 32'h8000_0100) begin bad++; $display("FAIL beq_pcM got=%h exp=80000100", pcM); end
        idle_cycles(2);
    endtask

    task automatic test_bne();
        drive_d(6'h05, 5'd0, 32'h8000_0200, 16'h0020, 1'b1, 1'b1);
        do_cycle();
        drive_nop(); rs_valueE = 32'd7; rt_valueE = 32'd7; #1;
        total++; if (mispredictE !== 1'b1) begin bad++; $display("FAIL bne_mispredict got=%b exp=1", mispredictE); end
        total++; if (redirect_pcE !== 32'h8000_0208) begin bad++; $display("FAIL bne_redirect got=%h exp=80000208", redirect_pcE); end
        do_cycle();
        total++; if (branchM !== 1'b1) begin bad++; $display("FAIL bne_branchM got=%b exp=1", branchM); end
        total++; if (actual_takeM !== 1'b0) begin bad++; $display("FAIL bne_takeM got=%b exp=0", actual_takeM); end
        idle_cycles(2);
    endtask

    task automatic test_bgtzl();
        drive_d(6'h17, 5'd0, 32'h8000_0300, 16'h0040, 1'b1, 1'b1);
        do_cycle();
        drive_nop(); rs_valueE = 32'hFFFF_FFFF; rt_valueE = 32'd0; #1;
        total++; if (mispredictE !== 1'b1) begin bad++; $display("FAIL bgtzl_mispredict got=%b exp=1", mispredictE); end
        total++; if (nullify_slotE !== 1'b1) begin bad++; $display("FAIL bgtzl_nullify got=%b exp=1", nullify_slotE); end
        total++; if (redirect_pcE !== 32'h8000_0308) begin bad++; $display("FAIL bgtzl_redirect got=%h exp=80000308", redirect_pcE); end
        idle_cycles(2);
    endtask

    task automatic test_stall_once();
        int pulses;
        pulses = 0;
        drive_d(6'h06, 5'd0, 32'h8000_0400, 16'h0008, 1'b1, 1'b1);
        do_cycle();
        drive_nop(); rs_valueE = 32'd0; rt_valueE = 32'd9; stallE = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            if (k <= 3) begin
                total++; if (mispredictE !== 1'b0) begin bad++; $display("FAIL stall_mispredict cycle=%0d got=%b exp=0", k, mispredictE); end
            end
            if (branchM === 1'b1) pulses++;
            if (k == 3) stallE = 1'b0;
            do_cycle();
        end
        total++; if (pulses !== 1) begin bad++; $display("FAIL stall_branchM_pulses got=%0d exp=1", pulses); end
        idle_cycles(2);
    endtask

    task automatic test_flush_stall();
        stallE = 1'b1; flushE = 1'b1;
        drive_d(6'h04, 5'd0, 32'h8000_0500, 16'h0004, 1'b1, 1'b1);
        do_cycle();
        stallE = 1'b0; flushE = 1'b0; drive_nop();
        rs_valueE = 32'd1; rt_valueE = 32'd2; #1;
        total++; if (mispredictE !== 1'b0) begin bad++; $display("FAIL flush_mispredict got=%b exp=0", mispredictE); end
        total++; if (nullify_slotE !== 1'b0) begin bad++; $display("FAIL flush_nullify got=%b exp=0", nullify_slotE); end
        do_cycle();
        total++; if (branchM !== 1'b0) begin bad++; $display("FAIL flush_branchM got=%b exp=0", branchM); end
        idle_cycles(2);
    endtask

    task automatic test_stall_flush_m();
        drive_d(6'h04, 5'd0, 32'h8000_0600, 16'h0004, 1'b1, 1'b1);
        do_cycle();
        drive_nop(); rs_valueE = 32'd3; rt_valueE = 32'd3;
        do_cycle();
        stallM = 1'b1;
        for (int k = 0; k < 2; k++) begin
            do_cycle();
            total++; if (branchM !== 1'b1) begin bad++; $display("FAIL stallM_branchM cycle=%0d got=%b exp=1", k, branchM); end
            total++; if (pcM !== 32'h8000_0600) begin bad++; $display("FAIL stallM_pcM cycle=%0d got=%h exp=80000600", k, pcM); end
        end
        flushM = 1'b1;
        do_cycle();
        total++; if (branchM !== 1'b0) begin bad++; $display("FAIL flushM_branchM got=%b exp=0", branchM); end
        total++; if (pcM !== 32'h8000_0600) begin bad++; $display("FAIL flushM_pcM got=%h exp=80000600", pcM); end
        stallM = 1'b0; flushM = 1'b0;
        idle_cycles(2);
    endtask

    task automatic test_reset_mid();
        drive_d(6'h04, 5'd0, 32'h8000_0700, 16'h0004, 1'b1, 1'b0);
        do_cycle();
        drive_d(6'h05, 5'd0, 32'h8000_0704, 16'h0004, 1'b1, 1'b0);
        rs_valueE = 32'd4; rt_valueE = 32'd4;
        do_cycle();
        stallE = 1'b1; rst = 1'b1;
        do_cycle();
        rs_valueE = 32'd1; rt_valueE = 32'd2; #1;
        total++; if (mispredictE !== 1'b0) begin bad++; $display("FAIL rstmid_mispredict got=%b exp=0", mispredictE); end
        total++; if (nullify_slotE !== 1'b0) begin bad++; $display("FAIL rstmid_nullify got=%b exp=0", nullify_slotE); end
        total++; if (branchM !== 1'b0) begin bad++; $display("FAIL rstmid_branchM got=%b exp=0", branchM); end
        total++; if (actual_takeM !== 1'b0) begin bad++; $display("FAIL rstmid_takeM got=%b exp=0", actual_takeM); end
        total++; if (pcM !== RST_PC) begin bad++; $display("FAIL rstmid_pcM got=%h exp=%h", pcM, RST_PC); end
`ifdef BRANCH_PERF_EN
        total++; if (perf_branch_cnt !== 32'd0) begin bad++; $display("FAIL rstmid_perf_branch got=%0d exp=0", perf_branch_cnt); end
        total++; if (perf_mispred_cnt !== 32'd0) begin bad++; $display("FAIL rstmid_perf_mispred got=%0d exp=0", perf_mispred_cnt); end
`endif
        rst = 1'b0; stallE = 1'b0; drive_nop();
        for (int k = 0; k < 2; k++) begin
            do_cycle();
            total++; if (branchM !== 1'b0) begin bad++; $display("FAIL rstmid_no_update cycle=%0d got=%b exp=0", k, branchM); end
        end
    endtask

    task automatic test_random();
        logic [5:0]  ops [9];
        logic [4:0]  rts [8];
        txn_t        e_t, m_t, n_t;
        logic [15:0] off;
        logic [31:0] rs, rt, exp_redirect;
        logic        take;
        ops = '{6'h04, 6'h05, 6'h06, 6'h07, 6'h14, 6'h15, 6'h16, 6'h17, 6'h01};
        rts = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd16, 5'd17, 5'd18, 5'd19};
        idle_cycles(2);
        e_t = '{br: 1'b0, lk: 1'b0, pt: 1'b0, tk: 1'b0, instr: 32'd0, pc: 32'd0, imm: 32'd0};
        m_t = e_t;
        for (int i = 0; i < 300; i++) begin
            off       = 16'($urandom);
            n_t.br    = ($urandom_range(0, 9) != 0);
            n_t.instr = {n_t.br ? ops[$urandom_range(0, 8)] : 6'h09, 5'd3, rts[$urandom_range(0, 7)], off};
            n_t.pc    = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            n_t.imm   = {{16{off[15]}}, off};
            n_t.lk    = n_t.br & ref_likely(n_t.instr);
            n_t.pt    = n_t.br & 1'($urandom_range(0, 1));
            n_t.tk    = 1'b0;
            drive_d(n_t.instr[31:26], n_t.instr[20:16], n_t.pc, off, n_t.br, n_t.pt);
            case ($urandom_range(0, 4))
                0:       rs = 32'd0;
                1:       rs = 32'hFFFF_FFFF;
                2:       rs = 32'h8000_0000;
                3:       rs = 32'd1;
                default: rs = $urandom;
            endcase
            rt = ($urandom_range(0, 1) != 0) ? rs : $urandom;
            rs_valueE = rs; rt_valueE = rt; #1;
            take         = e_t.br && ref_cond(e_t.instr, rs, rt);
            exp_redirect = take ? (e_t.pc + 32'd4 + (e_t.imm << 2)) : (e_t.pc + 32'd8);
            total++; if (mispredictE !== (e_t.br && (take != e_t.pt))) begin bad++; $display("FAIL rand_mispredict i=%0d got=%b exp=%b", i, mispredictE, e_t.br && (take != e_t.pt)); end
            total++; if (nullify_slotE !== (e_t.br && e_t.lk && !take)) begin bad++; $display("FAIL rand_nullify i=%0d got=%b exp=%b", i, nullify_slotE, e_t.br && e_t.lk && !take); end
            if (e_t.br) begin
                total++; if (redirect_pcE !== exp_redirect) begin bad++; $display("FAIL rand_redirect i=%0d got=%h exp=%h", i, redirect_pcE, exp_redirect); end
            end
            total++; if (branchM !== m_t.br) begin bad++; $display("FAIL rand_branchM i=%0d got=%b exp=%b", i, branchM, m_t.br); end
            total++; if (actual_takeM !== m_t.tk) begin bad++; $display("FAIL rand_takeM i=%0d got=%b exp=%b", i, actual_takeM, m_t.tk); end
            if (m_t.br) begin
                total++; if (pcM !== m_t.pc) begin bad++; $display("FAIL rand_pcM i=%0d got=%h exp=%h", i, pcM, m_t.pc); end
            end
            m_t    = e_t;
            m_t.tk = take;
            e_t    = n_t;
            do_cycle();
        end
        idle_cycles(2);
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_beq();
        test_bne();
        test_bgtzl();
        test_stall_once();
        test_flush_stall();
        test_stall_flush_m();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
